// File: rtl/write_buffer_pkg.sv
// =============================================================================
// Module : write_buffer_pkg
// Brief  : Bus operation encodings, FIFO entry layout and busop helpers
//          shared by the posted write buffer.
// Rev    : 1.0
// =============================================================================
`default_nettype none

package write_buffer_pkg;

    localparam logic [2:0] BUSOP_READB  = 3'd0;
    localparam logic [2:0] BUSOP_READH  = 3'd1;
    localparam logic [2:0] BUSOP_READW  = 3'd2;
    localparam logic [2:0] BUSOP_WRITEB = 3'd4;
    localparam logic [2:0] BUSOP_WRITEH = 3'd5;
    localparam logic [2:0] BUSOP_WRITEW = 3'd6;

    typedef struct packed {
        logic [2:0]  busop;
        logic [31:0] addr;
        logic [31:0] data;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);

    function automatic logic is_write(input logic [2:0] op);
        return (op == BUSOP_WRITEB) || (op == BUSOP_WRITEH) || (op == BUSOP_WRITEW);
    endfunction

    function automatic logic is_read(input logic [2:0] op);
        return (op == BUSOP_READB) || (op == BUSOP_READH) || (op == BUSOP_READW);
    endfunction

endpackage

`default_nettype wire

// File: rtl/write_buffer_fifo.sv
// =============================================================================
// Module : write_buffer_fifo
// Brief  : Generic DEPTH x WIDTH storage FIFO exporting every entry and its
//          valid bit for parallel address compares.
// Rev    : 1.0
// =============================================================================
`default_nettype none

module write_buffer_fifo
    import write_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_head,
    output logic [DEPTH-1:0][WIDTH-1:0]  o_entries,
    output logic [DEPTH-1:0]             o_valid,
    output logic [CNT_W-1:0]             o_count
);

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic [PTR_W-1:0]            r_head;
    logic [PTR_W-1:0]            r_tail;
    logic [CNT_W-1:0]            r_count;
    logic [DEPTH-1:0]            r_valid;

    // Payload is deliberately left unreset; only the bookkeeping is cleared.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_tail] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (i_push) begin
                r_tail          <= r_tail + 1'b1;
                r_valid[r_tail] <= 1'b1;
            end
            if (i_pop) begin
                r_head          <= r_head + 1'b1;
                r_valid[r_head] <= 1'b0;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head    = r_mem[r_head];
    assign o_entries = r_mem;
    assign o_valid   = r_valid;
    assign o_count   = r_count;

endmodule

`default_nettype wire

// File: rtl/write_buffer.sv
// =============================================================================
// Module : write_buffer
// Brief  : Posted CPU write buffer draining in order to memory, with a read
//          hazard flag for reads that hit a pending write's word.
// Rev    : 1.0
// =============================================================================
`default_nettype none

module write_buffer
    import write_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              I_clk,
    input  logic              I_reset_n,
    input  logic              I_req,
    input  logic [2:0]        I_busop,
    input  logic [31:0]       I_addr,
    input  logic [31:0]       I_data,
    output logic              O_ack,
    output logic              O_read_hazard,
    output logic              O_mem_req,
    output logic [2:0]        O_mem_busop,
    output logic [31:0]       O_mem_addr,
    output logic [31:0]       O_mem_data,
    input  logic              I_mem_ack,
    output logic              O_empty,
    output logic [CNT_W-1:0]  O_count
);

    typedef enum logic {
        WB_IDLE  = 1'b0,
        WB_ISSUE = 1'b1
    } wb_state_t;

    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    wb_state_t                        r_state;
    logic                             r_ack;
    logic                             r_mem_req;
    logic                             w_push;
    logic                             w_pop;
    logic                             w_hit;
    logic [CNT_W-1:0]                 w_count;
    logic [DEPTH-1:0]                 w_valid;
    logic [DEPTH-1:0][ENTRY_W-1:0]    w_entries;
    logic [ENTRY_W-1:0]               w_head;
    wb_entry_t                        w_head_e;
    wb_entry_t                        w_ent;

    // Count is sampled before any same-edge pop, so a full buffer never accepts.
    assign w_push = I_req & is_write(I_busop) & (w_count < C_FULL) & ~r_ack;
    assign w_pop  = (r_state == WB_ISSUE) & I_mem_ack;

    write_buffer_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .i_clk     (I_clk),
        .i_rst_n   (I_reset_n),
        .i_push    (w_push),
        .i_data    ({I_busop, I_addr, I_data}),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_entries (w_entries),
        .o_valid   (w_valid),
        .o_count   (w_count)
    );

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            r_state   <= WB_IDLE;
            r_ack     <= 1'b0;
            r_mem_req <= 1'b0;
        end else begin
            r_ack <= w_push;
            case (r_state)
                WB_IDLE: begin
                    if (w_count != '0) begin
                        r_state   <= WB_ISSUE;
                        r_mem_req <= 1'b1;
                    end
                end
                WB_ISSUE: begin
                    if (I_mem_ack) begin
                        r_state   <= WB_IDLE;
                        r_mem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= WB_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Word-granular compare against every valid entry, including the one in flight.
    always_comb begin
        w_hit = 1'b0;
        w_ent = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_ent = w_entries[i];
            if (w_valid[i] && (w_ent.addr[31:2] == I_addr[31:2])) begin
                w_hit = 1'b1;
            end
        end
    end

    assign w_head_e      = w_head;
    assign O_ack         = r_ack;
    assign O_read_hazard = I_req & is_read(I_busop) & w_hit;
    assign O_mem_req     = r_mem_req;
    assign O_mem_busop   = w_head_e.busop;
    assign O_mem_addr    = w_head_e.addr;
    assign O_mem_data    = w_head_e.data;
    assign O_empty       = (w_count == '0) & (r_state == WB_IDLE);
    assign O_count       = w_count;

endmodule

`default_nettype wire
